// File: rtl/bits_pkg.sv
// bits_pkg: constants and types shared by the BITS bit reader, core and register block.
package bits_pkg;

    localparam int BUF_W   = 32;
    localparam int MAX_FLD = 16;
    localparam int CNT_W   = 16;

    localparam logic [4:0] FLD_LEN_MIN = 5'd1;
    localparam logic [4:0] FLD_LEN_MAX = 5'd16;

    typedef enum logic {IDLE, RUN} state_t;

    function automatic logic fld_len_ok(input logic [4:0] len);
        return len >= FLD_LEN_MIN && len <= FLD_LEN_MAX;
    endfunction

endpackage

// File: rtl/bits_bit_reader.sv
// bits_bit_reader: MSB-first byte-to-bitfield front end of the BITS decoder.
module bits_bit_reader #(
    parameter int BUF_W   = bits_pkg::BUF_W,
    parameter int MAX_FLD = bits_pkg::MAX_FLD,
    parameter int CNT_W   = bits_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [CNT_W-1:0]   expected_bytes,
    input  logic [7:0]         byte_data,
    input  logic               byte_valid,
    output logic               byte_ready,
    input  logic               fld_req,
    input  logic [4:0]         fld_len,
    output logic               fld_ack,
    output logic [MAX_FLD-1:0] fld_data,
    output logic               fld_err,
    output logic [CNT_W+2:0]   bits_consumed,
    output logic               drained
);
    import bits_pkg::*;

    localparam int CW = $clog2(BUF_W + 1);

    state_t             state, state_n;
    logic [BUF_W-1:0]   bit_buf, buf_n;
    logic [CW-1:0]      count, count_n, take, rem;
    logic [CNT_W-1:0]   bytes_left, left_n;
    logic [CNT_W+3:0]   bc_sum;
    logic [CNT_W+2:0]   bc_n;
    logic [4:0]         len_q, len_e;
    logic               pending, accept, req, legal, serve, fail;

    function automatic logic [MAX_FLD-1:0] extract(input logic [BUF_W-1:0] b, input logic [4:0] len);
        logic [BUF_W-1:0] s;
        s = b >> (BUF_W - int'(len));
        return s[MAX_FLD-1:0];
    endfunction

    assign byte_ready = state == RUN && bytes_left != '0 && count <= CW'(BUF_W - 8);

    // A fresh request is evaluated in its own cycle so a ready field acks one cycle later.
    always_comb begin
        state_n = start ? RUN : state;
        accept  = byte_valid & byte_ready;
        req     = pending | (state == RUN & fld_req);
        len_e   = pending ? len_q : fld_len;
        legal   = fld_len_ok(len_e);
        serve   = req & legal & (count >= CW'(len_e));
        fail    = req & (!legal | ((count < CW'(len_e)) & bytes_left == '0));
        take    = serve ? CW'(len_e) : '0;
        rem     = count - take;
        buf_n   = (bit_buf << take) | (accept ? ({byte_data, {(BUF_W-8){1'b0}}} >> rem) : '0);
        count_n = rem + (accept ? CW'(8) : '0);
        left_n  = bytes_left - CNT_W'(accept);
        bc_sum  = {1'b0, bits_consumed} + (CNT_W+4)'(take);
        bc_n    = bc_sum[CNT_W+3] ? '1 : bc_sum[CNT_W+2:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            bit_buf       <= '0;
            count         <= '0;
            bytes_left    <= '0;
            pending       <= 1'b0;
            len_q         <= '0;
            fld_ack       <= 1'b0;
            fld_err       <= 1'b0;
            fld_data      <= '0;
            bits_consumed <= '0;
            drained       <= 1'b0;
        end else if (start) begin
            state         <= state_n;
            bit_buf       <= '0;
            count         <= '0;
            bytes_left    <= expected_bytes;
            pending       <= 1'b0;
            len_q         <= '0;
            fld_ack       <= 1'b0;
            fld_err       <= 1'b0;
            fld_data      <= '0;
            bits_consumed <= '0;
            drained       <= expected_bytes == '0;
        end else begin
            state         <= state_n;
            bit_buf       <= buf_n;
            count         <= count_n;
            bytes_left    <= left_n;
            pending       <= req & !serve & !fail;
            len_q         <= len_e;
            fld_ack       <= serve | fail;
            fld_err       <= fail;
            fld_data      <= serve ? extract(bit_buf, len_e) : '0;
            bits_consumed <= bc_n;
            drained       <= state_n == RUN && left_n == '0 && count_n == '0;
        end
    end

endmodule

// File: tb/tb_bits_bit_reader.sv
// tb_bits_bit_reader: directed table-driven bench for the BITS bit reader.
module tb_bits_bit_reader;

    logic        clk = 1'b0;
    logic        reset, start, byte_valid, byte_ready, fld_req, fld_ack, fld_err, drained;
    logic [15:0] expected_bytes, fld_data;
    logic [7:0]  byte_data;
    logic [4:0]  fld_len;
    logic [18:0] bits_consumed;

    int checks = 0;
    int errors = 0;
    int acc = 0;

    typedef struct {
        logic [4:0]  len;
        logic [15:0] data;
        logic        err;
    } vec_t;

    vec_t       v[11];
    logic [7:0] vals[6];

    bits_bit_reader dut (
        .clk(clk), .reset(reset), .start(start), .expected_bytes(expected_bytes),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .fld_req(fld_req), .fld_len(fld_len), .fld_ack(fld_ack), .fld_data(fld_data),
        .fld_err(fld_err), .bits_consumed(bits_consumed), .drained(drained)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [15:0] n);
        start = 1'b1;
        expected_bytes = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int k = 0;
        byte_valid = 1'b1;
        byte_data = b;
        while (!byte_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("send_ready", {31'b0, byte_ready}, 1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic req(input string nm, input logic [4:0] l, input logic [15:0] d, input logic e);
        int k = 0;
        fld_req = 1'b1;
        fld_len = l;
        @(negedge clk);
        fld_req = 1'b0;
        while (!fld_ack && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_ack"}, {31'b0, fld_ack}, 1);
        chk({nm, "_lat"}, k, 0);
        chk({nm, "_data"}, {16'b0, fld_data}, {16'b0, d});
        chk({nm, "_err"}, {31'b0, fld_err}, {31'b0, e});
        @(negedge clk);
        chk({nm, "_drop"}, {14'b0, fld_ack, fld_err, fld_data}, 0);
    endtask

    task automatic run_vec(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) req($sformatf("vec%0d", i), v[i].len, v[i].data, v[i].err);
    endtask

    task automatic feed(input int n);
        for (int c = 0; c < n; c++) begin
            byte_valid = acc < 6;
            byte_data = vals[acc % 6];
            @(posedge clk);
            if (byte_valid && byte_ready) acc++;
            @(negedge clk);
        end
        byte_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        v[0]  = '{5'd3,  16'h0006, 1'b0};
        v[1]  = '{5'd3,  16'h0004, 1'b0};
        v[2]  = '{5'd5,  16'h0017, 1'b0};
        v[3]  = '{5'd3,  16'h0001, 1'b0};
        v[4]  = '{5'd3,  16'h0006, 1'b0};
        v[5]  = '{5'd1,  16'h0000, 1'b0};
        v[6]  = '{5'd15, 16'h001B, 1'b0};
        v[7]  = '{5'd5,  16'h0014, 1'b0};
        v[8]  = '{5'd4,  16'h0000, 1'b1};
        v[9]  = '{5'd0,  16'h0000, 1'b1};
        v[10] = '{5'd17, 16'h0000, 1'b1};
        vals  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        reset = 1'b1; start = 1'b0; expected_bytes = '0; byte_data = '0;
        byte_valid = 1'b0; fld_req = 1'b0; fld_len = '0;
        repeat (2) @(negedge clk);
        chk("reset_outs", {byte_ready, fld_ack, fld_err, drained, fld_data}, 0);
        chk("reset_bc", {13'b0, bits_consumed}, 0);
        reset = 1'b0;
        @(negedge clk);

        do_start(16'd2);
        send(8'hD2);
        send(8'hFE);
        run_vec(0, 2);
        chk("t1_bc", {13'b0, bits_consumed}, 11);
        chk("t1_drained", {31'b0, drained}, 0);

        do_start(16'd3);
        chk("t2_bc_clear", {13'b0, bits_consumed}, 0);
        send(8'h38);
        send(8'h00);
        send(8'h6F);
        run_vec(3, 6);
        chk("t2_bc", {13'b0, bits_consumed}, 22);

        do_start(16'd6);
        acc = 0;
        feed(10);
        chk("t3_accepted", acc, 4);
        chk("t3_full_ready", {31'b0, byte_ready}, 0);
        req("t3_a", 5'd16, 16'h1122, 1'b0);
        feed(6);
        chk("t3_accepted_all", acc, 6);
        req("t3_b", 5'd16, 16'h3344, 1'b0);
        req("t3_c", 5'd16, 16'h5566, 1'b0);
        chk("t3_drained", {31'b0, drained}, 1);
        chk("t3_bc", {13'b0, bits_consumed}, 48);

        do_start(16'd1);
        send(8'hA5);
        run_vec(7, 10);
        chk("t4_bc", {13'b0, bits_consumed}, 5);

        do_start(16'd0);
        chk("zero_drained", {31'b0, drained}, 1);
        chk("zero_ready", {31'b0, byte_ready}, 0);
        req("zero_req", 5'd1, 16'h0000, 1'b1);

        do_start(16'd2);
        fld_req = 1'b1;
        fld_len = 5'd3;
        @(negedge clk);
        fld_req = 1'b0;
        chk("t5_pending", {31'b0, fld_ack}, 0);
        do_start(16'd1);
        for (int i = 0; i < 3; i++) begin
            chk("t5_no_ack", {31'b0, fld_ack}, 0);
            @(negedge clk);
        end
        chk("t5_bc", {13'b0, bits_consumed}, 0);
        send(8'hFF);
        req("t5_req", 5'd8, 16'h00FF, 1'b0);
        chk("t5_drained", {31'b0, drained}, 1);
        chk("t5_bc8", {13'b0, bits_consumed}, 8);

        do_start(16'd3);
        send(8'hAB);
        fld_req = 1'b1;
        fld_len = 5'd16;
        @(negedge clk);
        fld_req = 1'b0;
        chk("t6_ready_before", {31'b0, byte_ready}, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_outs", {byte_ready, fld_ack, fld_err, drained, fld_data}, 0);
        chk("t6_bc", {13'b0, bits_consumed}, 0);
        reset = 1'b0;
        fld_req = 1'b1;
        fld_len = 5'd4;
        byte_valid = 1'b1;
        @(negedge clk);
        fld_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t6_idle", {30'b0, fld_ack, byte_ready}, 0);
            @(negedge clk);
        end
        byte_valid = 1'b0;
        do_start(16'd1);
        send(8'h5A);
        req("t6_recover", 5'd4, 16'h0005, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bits_bit_reader.md
Name: bits_bit_reader

Overview:
Bit-stream front end of the BITS decoder; sits between the byte input path and the BITS core, alongside the APB register block.
- Accepts the hex-decoded packet stream one byte at a time (valid/ready) and buffers it MSB-first.
- Serves variable-width field requests of 1..16 bits from the core (version, type ID, literal groups, length fields).
- Armed by the register block's start pulse and expected_bytes; reports total bits consumed so the core can bound length-type-0 sub-packet regions.

Parameters:
BUF_W, 32, bit-buffer width; must be at least MAX_FLD+8
MAX_FLD, 16, largest field width one request may return
CNT_W, 16, width of the byte counter (expected_bytes)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse from the register block; arms a new stream
expected_bytes  input  CNT_W  number of bytes in the stream, sampled on start
byte_data  input  8  next stream byte, MSB is the first bit
byte_valid  input  1  byte_data is valid
byte_ready  output  1  byte accepted when byte_valid & byte_ready
fld_req  input  1  one-cycle request pulse
fld_len  input  5  requested width; legal range 1..16
fld_ack  output  1  one-cycle completion pulse
fld_data  output  MAX_FLD  field value, right-aligned and zero-extended; valid with fld_ack
fld_err  output  1  valid with fld_ack; 1 = illegal length or stream underflow
bits_consumed  output  CNT_W+3  total bits handed to the core since start
drained  output  1  all expected bytes accepted and buffer empty

Behaviour:
- States: IDLE and RUN. Reset enters IDLE; start enters RUN from any state.
- Reset values: byte_ready=0, fld_ack=0, fld_data=0, fld_err=0, bits_consumed=0, drained=0, buffer count=0, no request pending.
- start (from any state, including mid-stream):
  - clears buffer, count, bits_consumed and any pending request;
  - loads bytes_left=expected_bytes;
  - fld_req or bytes presented in the start cycle are ignored.
- Buffer: left-aligned; the count valid bits occupy buf[BUF_W-1 -: count].
- Fill:
  - byte_ready = RUN & bytes_left!=0 & count<=BUF_W-8, computed from registered state only.
  - On accept, the byte is placed immediately after the remaining valid bits and bytes_left is decremented.
- Request acceptance:
  - In RUN, fld_req with no request pending latches fld_len and sets pending.
  - fld_req while pending, or in IDLE, is ignored.
- Service: on the first cycle with pending & count>=len, register fld_ack=1, fld_data = top len bits of the buffer, fld_err=0.
  - In the same edge, shift the buffer left by len, subtract len from count, add len to bits_consumed, clear pending.
  - Minimum latency is 1 cycle: request in cycle N, ack in cycle N+1.
- Simultaneous fill and consume in one edge is legal:
  - next_buf = (buf<<len) | (byte << (BUF_W-8-(count-len))).
  - next_count = count - len + 8.
- Illegal length (fld_len=0 or >16): next cycle fld_ack=1, fld_err=1, fld_data=0; buffer and counters unchanged.
- Underflow (pending, count<len, bytes_left==0): fld_ack=1, fld_err=1, fld_data=0; no bits consumed; pending cleared.
- expected_bytes=0: byte_ready never asserts; drained=1 one cycle after start; every request underflows.
- drained = RUN & bytes_left==0 & count==0, registered.
- bits_consumed saturates at its maximum and never wraps.
- fld_ack, fld_err and fld_data hold for exactly one cycle; fld_ack, fld_err and fld_data return to 0 afterwards.

Decomposition:
- Shared package bits_pkg: BUF_W, MAX_FLD, CNT_W, state encoding (IDLE/RUN), fld_len legal-range constants. These constants are also used by the core and the register block.
- No sub-module: shift/insert logic and the FSM fit in one module.
- Field extraction may be an internal function.

Test Plan:
1. Basic extraction: start with expected_bytes=2; bytes 0xD2, 0xFE; requests 3,3,5 → fld_data 6, 4, 0x17; fld_err=0 each; bits_consumed=11; each ack one cycle after its request.
2. Wide field across bytes: expected_bytes=3; bytes 0x38, 0x00, 0x6F; requests 3,3,1,15 → fld_data 1, 6, 0, 27 (0x001B); bits_consumed=22.
3. Back-pressure: expected_bytes=6, all 6 bytes presented back-to-back, no requests → exactly 4 accepted, byte_ready=0 at count=32. Request 16 → remaining bytes accepted as count frees.
4. Underflow and illegal length: expected_bytes=1, byte 0xA5; request 5 → 0x14. Request 4 → fld_err=1, data 0, bits_consumed stays 5. Request len 0 → fld_err=1.
5. Restart mid-stream: after test 1's first request, pulse start with expected_bytes=1 while a request is pending → no ack for the old request, bits_consumed=0; byte 0xFF then request 8 → 0xFF; drained=1.
6. Reset mid-operation: assert reset with a pending request and a partial buffer → all outputs 0 next cycle, IDLE; fld_req ignored until the next start.
